fnd_scan_controller: RTL

//  Time-multiplexed scan driver for the 4-digit FND display. Divides the system

---
 rtl/fnd_scan_controller.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan driver: prescaled digit stepping, frame-latched value/dp,
// and registered select/nibble/dp/blank outputs that always change together.
module fnd_scan_controller #(
  parameter int TICK_DIV      = 100_000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dpMask,
  output logic [1:0]  o_select,
  output logic [3:0]  o_digitValue,
  output logic        o_dp,
  output logic        o_blank,
  output logic        o_frameStart
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} scan_state_t;

  scan_state_t     state_q, state_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [15:0]     shadow_val_q, shadow_val_d;
  logic [3:0]      shadow_dp_q, shadow_dp_d;
  logic [3:0]      digit_q, digit_d;
  logic            dp_q, dp_d;
  logic            blank_q, blank_d;
  logic            frame_q, frame_d;

  logic            tick;
  logic            wrap;
  logic [15:0]     src_val;
  logic [3:0]      src_dp;

  function automatic logic [3:0] nibble_of(input logic [15:0] val, input logic [1:0] sel);
    return val[{sel, 2'b00} +: 4];
  endfunction

  // A digit is dark only when it and every more-significant nibble are zero.
  function automatic logic blank_of(input logic [15:0] val, input logic [1:0] sel);
    logic b;
    case (sel)
      2'd1:    b = (val[15:4] == 12'h000);
      2'd2:    b = (val[15:8] == 8'h00);
      2'd3:    b = (val[15:12] == 4'h0);
      default: b = 1'b0;
    endcase
    return b && (BLANK_LEADING != 1'b0);
  endfunction

  assign tick    = i_enable && (presc_q == PS_LAST);
  assign wrap    = tick && (state_q == S3);
  assign src_val = wrap ? i_value : shadow_val_q;
  assign src_dp  = wrap ? i_dpMask : shadow_dp_q;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    digit_d      = digit_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    frame_d      = 1'b0;

    if (i_enable) begin
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
    end

    if (tick) begin
      case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = S3;
        default: state_d = S0;
      endcase
      digit_d = nibble_of(src_val, state_d);
      dp_d    = src_dp[state_d];
      blank_d = blank_of(src_val, state_d);
    end

    if (wrap) begin
      shadow_val_d = i_value;
      shadow_dp_d  = i_dpMask;
      frame_d      = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S0;
      presc_q      <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      digit_q      <= '0;
      dp_q         <= 1'b0;
      blank_q      <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      frame_q      <= frame_d;
    end
  end

  assign o_select     = state_q;
  assign o_digitValue = digit_q;
  assign o_dp         = dp_q;
  assign o_blank      = blank_q;
  assign o_frameStart = frame_q;

endmodule
